// File: rtl/dac_serial_rx.sv
// dac_serial_rx: oversampling receiver for the 3-wire DAC link (sync, sclk, din).
// Recovers FRAME_BITS-bit frames MSB-first and strobes valid for one cycle.
// Optional feature macro: DAC_RX_ERR_EN adds the frame_err short-frame strobe.
module dac_serial_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  sync_in,
  input  logic                  din_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic [1:0]            mode_out,
  output logic [FRAME_BITS-5:0] code_out,
  output logic                  valid,
  output logic                  busy
`ifdef DAC_RX_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sy, sync_sy, din_sy;
  logic                   sclk_c, sclk_p, sync_c, sync_p, din_c;
  logic                   fe, sf, sr;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_inc;
  logic [FRAME_BITS-1:0]  sh, sh_n, sh_shift, dout_n;
  logic                   valid_n;
`ifdef DAC_RX_ERR_EN
  logic                   ferr_n;
`endif

  // Identical synchronizer chains on all three pins keep their relative timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sy <= '0;
      sync_sy <= '0;
      din_sy  <= '0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_in};
      sync_sy <= {sync_sy[SYNC_STAGES-2:0], sync_in};
      din_sy  <= {din_sy[SYNC_STAGES-2:0], din_in};
    end
  end

  // Current/previous registers for edge detection; din gets the same delay as cur.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_c <= 1'b0;
      sclk_p <= 1'b0;
      sync_c <= 1'b0;
      sync_p <= 1'b0;
      din_c  <= 1'b0;
    end else begin
      sclk_c <= sclk_sy[SYNC_STAGES-1];
      sclk_p <= sclk_c;
      sync_c <= sync_sy[SYNC_STAGES-1];
      sync_p <= sync_c;
      din_c  <= din_sy[SYNC_STAGES-1];
    end
  end

  assign fe = sclk_p & ~sclk_c;
  assign sf = sync_p & ~sync_c;
  assign sr = ~sync_p & sync_c;

  // State, counter, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
`ifdef DAC_RX_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      data_out  <= dout_n;
      valid     <= valid_n;
`ifdef DAC_RX_ERR_EN
      frame_err <= ferr_n;
`endif
    end
  end

  assign sh_shift = {sh[FRAME_BITS-2:0], din_c};
  assign cnt_inc  = cnt + 1'b1;

  // Next-state: the fe is handled before a coincident sr, so a last bit
  // landing with sync rising still completes the frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    dout_n  = data_out;
    valid_n = 1'b0;
`ifdef DAC_RX_ERR_EN
    ferr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sf) begin
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (fe) begin
          sh_n  = sh_shift;
          cnt_n = cnt_inc;
        end
        if (fe && (cnt_inc == CW'(FRAME_BITS))) begin
          dout_n  = sh_shift;
          valid_n = 1'b1;
          state_n = sr ? IDLE : DONE;
        end else if (sr) begin
`ifdef DAC_RX_ERR_EN
          ferr_n  = 1'b1;
`endif
          state_n = IDLE;
        end
      end
      DONE: begin
        if (sr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state == SHIFT);
  assign mode_out = data_out[FRAME_BITS-3:FRAME_BITS-4];
  assign code_out = data_out[FRAME_BITS-5:0];

endmodule
